// File: rtl/fe25519_pkg.sv
// Shared constants and types for the Curve25519 field arithmetic datapath.
// p = 2^255 - 19 and the two fold widths used by the reduction pipeline.
package fe25519_pkg;

  localparam int unsigned FE_W = 255;
  localparam int unsigned C19  = 19;

  // 2^255 - 19: upper 250 bits set, low five bits 5'b01101
  localparam logic [FE_W-1:0] P = {{250{1'b1}}, 5'b01101};

  // lo + 19*hi for a 255-bit hi stays below 2^260
  localparam int unsigned S1_W = 261;
  // lo + 19*h2 for a 6-bit h2 stays below 2p
  localparam int unsigned S2_W = 256;

  typedef logic [FE_W-1:0]   fe_t;
  typedef logic [2*FE_W-1:0] wide_t;

endpackage

// File: rtl/fold19.sv
// Folds the bits above 2^255 back into the low word using 2^255 = 19 (mod p).
// sum_o = lo_i + 19*hi_i, with the multiply built from shifts and adds.
module fold19
  import fe25519_pkg::*;
#(
  parameter int unsigned HiW  = 255,
  parameter int unsigned OutW = 261
) (
  input  fe_t              lo_i,
  input  logic [HiW-1:0]   hi_i,
  output logic [OutW-1:0]  sum_o
);

  logic [OutW-1:0] hi_ext;
  logic [OutW-1:0] lo_ext;

  always_comb begin
    hi_ext = OutW'(hi_i);
    lo_ext = OutW'(lo_i);
    // 19*x = 16x + 2x + x
    sum_o  = lo_ext + (hi_ext << 4) + (hi_ext << 1) + hi_ext;
  end

endmodule

// File: rtl/reduce.sv
// Three-stage pipeline reducing a 510-bit operand modulo 2^255 - 19 to the
// canonical residue: two folds by 19, then a single conditional subtract of p.
module reduce
  import fe25519_pkg::*;
#(
  parameter int unsigned N = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*N-1:0] n,
  output logic           out_valid,
  output logic [N-1:0]   r
);

  logic [S1_W-1:0] s1_d, s1_q;
  logic [S2_W-1:0] s2_d, s2_q;
  logic [S2_W-1:0] diff;
  fe_t             r_d, r_q;
  logic [2:0]      valid_q;

  fold19 #(
    .HiW  (FE_W),
    .OutW (S1_W)
  ) u_fold1 (
    .lo_i  (n[FE_W-1:0]),
    .hi_i  (n[2*FE_W-1:FE_W]),
    .sum_o (s1_d)
  );

  fold19 #(
    .HiW  (S1_W - FE_W),
    .OutW (S2_W)
  ) u_fold2 (
    .lo_i  (s1_q[FE_W-1:0]),
    .hi_i  (s1_q[S1_W-1:FE_W]),
    .sum_o (s2_d)
  );

  // s2 < 2p, so one subtraction always lands in [0, p-1]
  always_comb begin
    diff = s2_q - {1'b0, P};
    if (s2_q >= {1'b0, P}) begin
      r_d = diff[FE_W-1:0];
    end else begin
      r_d = s2_q[FE_W-1:0];
    end
  end

  // Data registers load every cycle; only the valid pipe carries meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      r_q     <= '0;
      valid_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      r_q     <= r_d;
      valid_q <= {valid_q[1:0], in_valid};
    end
  end

  assign out_valid = valid_q[2];
  assign r         = r_q;

endmodule

// File: tb/tb_reduce.sv
// Self-checking bench for reduce: directed corner values, stage-3 boundary
// operands, asynchronous reset mid-stream and a long random stream with gaps.
module tb_reduce;

  localparam logic [255:0] PFull = (256'd1 << 255) - 256'd19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [509:0] n = '0;
  logic         out_valid;
  logic [254:0] r;

  int checks = 0;
  int failures = 0;

  // expected contents of the three pipeline slots, oldest in slot 2
  logic         exp_v [3];
  logic [254:0] exp_r [3];
  string        exp_t [3];

  always #5 clk = ~clk;

  reduce #(
    .N (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .n         (n),
    .out_valid (out_valid),
    .r         (r)
  );

  function automatic logic [254:0] ref_mod(input logic [509:0] x);
    logic [509:0] q;
    q = x % {254'b0, PFull};
    return q[254:0];
  endfunction

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      exp_v[i] = 1'b0;
      exp_r[i] = '0;
      exp_t[i] = "idle";
    end
  endtask

  // Drive one cycle; has_want overrides the model with a known constant.
  task automatic step(input logic v, input logic [509:0] x, input string tag,
                      input logic has_want, input logic [254:0] want);
    in_valid = v;
    n        = x;
    @(posedge clk);
    for (int i = 2; i > 0; i--) begin
      exp_v[i] = exp_v[i-1];
      exp_r[i] = exp_r[i-1];
      exp_t[i] = exp_t[i-1];
    end
    exp_v[0] = v;
    exp_r[0] = has_want ? want : ref_mod(x);
    exp_t[0] = tag;
    #1;
    check({exp_t[2], " valid"}, 255'(out_valid), 255'(exp_v[2]));
    if (exp_v[2]) check(exp_t[2], r, exp_r[2]);
  endtask

  task automatic bubbles(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, '0, "bubble", 1'b0, '0);
  endtask

  function automatic logic [509:0] rand_wide();
    logic [511:0] w;
    w = '0;
    for (int j = 0; j < 16; j++) w = {w[479:0], 32'($urandom)};
    return w[509:0];
  endfunction

  initial begin
    logic [511:0] t;
    logic [509:0] x;
    logic [260:0] s1t, hi, lo;
    int           k;

    clear_model();
    #1;
    check("reset valid", 255'(out_valid), 255'(0));
    check("reset r", r, '0);
    #11;
    rst_n = 1'b1;

    // directed values, back to back
    step(1'b1, '0, "n=0", 1'b1, 255'd0);
    step(1'b1, 510'd2, "n=2", 1'b1, 255'd2);
    step(1'b1, {255'b0, PFull[254:0] - 255'd1}, "n=p-1", 1'b1, PFull[254:0] - 255'd1);
    step(1'b1, {255'b0, PFull[254:0]}, "n=p", 1'b1, 255'd0);
    step(1'b1, 510'd1 << 255, "n=2^255", 1'b1, 255'd19);
    step(1'b1, {510{1'b1}}, "all ones", 1'b1, 255'd360);
    t = {16{32'hdeadbeef}} << 1;
    step(1'b1, t[509:0], "deadbeef", 1'b1,
         255'd40227885138464997724684449426672570397534900615285750892290072162437648363105);
    step(1'b1, (510'd1 << 255) - 510'd1, "n=2^255-1", 1'b1, 255'd18);
    bubbles(3);

    // operands whose second fold lands in [p, 2^255+1215]
    for (int h2 = 1; h2 <= 18; h2++) begin
      k   = int'($urandom_range(0, 30));
      s1t = (261'(h2) << 255) + ((261'd1 << 255) - 261'd1 - 261'(k));
      hi  = s1t / 261'd19;
      lo  = s1t - hi * 261'd19;
      step(1'b1, {hi[254:0], lo[254:0]}, "stage3 boundary", 1'b1,
           255'(19 * h2 + 18 - k));
    end
    bubbles(3);

    // asynchronous reset with results in flight
    for (int i = 0; i < 4; i++) step(1'b1, rand_wide(), "pre-reset", 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset valid", 255'(out_valid), 255'(0));
    check("async reset r", r, '0);
    clear_model();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("in reset valid", 255'(out_valid), 255'(0));
    rst_n = 1'b1;
    bubbles(4);
    step(1'b1, 510'd5, "post-reset", 1'b1, 255'd5);
    bubbles(3);

    // random stream with random gaps
    for (int i = 0; i < 1000; i++) begin
      x = rand_wide();
      if ($urandom_range(0, 7) == 0) x = x >> $urandom_range(250, 509);
      step($urandom_range(0, 3) != 0, x, "random", 1'b0, '0);
    end
    bubbles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
